// File: rtl/fpga_cmd_rx.sv
// rtl/fpga_cmd_rx.sv - SPI-style command frame receiver with register decode
//
// Purpose: receives CMD_W+DATA_W bit frames (MSB first) on an asynchronous
// ncs/spck/mosi link. Frames are oversampled in the clk domain, then decoded
// into configuration registers when ncs is released.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous reset, active-high
//   ncs        in   chip select, active-low, asynchronous
//   spck       in   serial clock, asynchronous
//   mosi       in   serial data, captured on spck rising edge
//   conf_reg   out  last committed configuration word   (cmd 0x1)
//   divisor    out  last committed clock divisor        (cmd 0x2)
//   threshold  out  last committed edge threshold       (cmd 0x3)
//   trace_en   out  last committed trace enable         (cmd 0x4)
//   cmd_valid  out  one-cycle pulse per accepted frame
//   cmd_code   out  command field of last accepted frame
//   frame_err  out  one-cycle pulse per rejected frame

module fpga_cmd_rx #(
  parameter int CMD_W  = 4,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ncs,
  input  logic              spck,
  input  logic              mosi,
  output logic [DATA_W-1:0] conf_reg,
  output logic [7:0]        divisor,
  output logic [7:0]        threshold,
  output logic              trace_en,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd_code,
  output logic              frame_err
);

  localparam int         FRAME_W = CMD_W + DATA_W;
  localparam logic [4:0] LEN     = 5'(FRAME_W);
  localparam logic [4:0] LEN_OVR = 5'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // [0],[1] form the synchronizer; [2] is the delayed copy used for edges.
  logic [2:0] ncs_q, spck_q;
  logic [1:0] mosi_q;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [4:0]           count_q, count_d;
  logic [DATA_W-1:0]    conf_q, conf_d;
  logic [7:0]           div_q, div_d;
  logic [7:0]           thr_q, thr_d;
  logic                 trace_q, trace_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [CMD_W-1:0]     code_q, code_d;

  logic                 ncs_fall, ncs_rise, spck_rise, mosi_s;
  logic [CMD_W-1:0]     cmd_field;

  assign ncs_fall  = ncs_q[2] & ~ncs_q[1];
  assign ncs_rise  = ~ncs_q[2] & ncs_q[1];
  assign spck_rise = ~spck_q[2] & spck_q[1];
  assign mosi_s    = mosi_q[1];
  assign cmd_field = shreg_q[FRAME_W-1 -: CMD_W];

  // Reset values match the idle line levels so leaving reset makes no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ncs_q  <= 3'b111;
      spck_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      ncs_q  <= {ncs_q[1:0], ncs};
      spck_q <= {spck_q[1:0], spck};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      conf_q  <= '0;
      div_q   <= '0;
      thr_q   <= 8'd127;
      trace_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      conf_q  <= conf_d;
      div_q   <= div_d;
      thr_q   <= thr_d;
      trace_q <= trace_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    conf_d  = conf_q;
    div_d   = div_q;
    thr_d   = thr_q;
    trace_d = trace_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          shreg_d = '0;
          count_d = '0;
        end
      end
      SHIFT: begin
        // An spck edge seen together with ncs release belongs to no frame.
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (spck_rise) begin
          // Bits past the frame length only push the counter to the
          // overrun value so the frame is rejected; shreg keeps the frame.
          if (count_q < LEN) shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
          if (count_q != LEN_OVR) count_d = count_q + 5'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (count_q == LEN) begin
          valid_d = 1'b1;
          code_d  = cmd_field;
          case (cmd_field)
            CMD_W'(1): conf_d  = shreg_q[DATA_W-1:0];
            CMD_W'(2): div_d   = shreg_q[7:0];
            CMD_W'(3): thr_d   = shreg_q[7:0];
            CMD_W'(4): trace_d = shreg_q[0];
            default: begin
              valid_d = 1'b0;
              code_d  = code_q;
              err_d   = 1'b1;
            end
          endcase
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign conf_reg  = conf_q;
  assign divisor   = div_q;
  assign threshold = thr_q;
  assign trace_en  = trace_q;
  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
  assign frame_err = err_q;

endmodule
